// File: rtl/gb_dma_pkg.sv
// Shared definitions for the OAM DMA engine: FSM states, transfer length and
// the echo-RAM fold applied to the source page.
package gb_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_XFER  = 2'd2
  } dma_state_t;

  localparam int unsigned OAM_LEN_DEFAULT = 32'd160;
  localparam logic [7:0]  ECHO_BASE       = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET     = 8'h20;

  // Echo pages E0..FF alias work RAM, so they are folded down by 0x20.
  function automatic logic [7:0] src_effective(input logic [7:0] src);
    logic [7:0] eff;
    if (src >= ECHO_BASE) begin
      eff = src - ECHO_OFFSET;
    end else begin
      eff = src;
    end
    return eff;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies OAM_LEN bytes from page {src,00} into OAM, one byte
// per machine cycle, after a one-cycle start-up delay.
module oam_dma
  import gb_dma_pkg::*;
#(
  parameter int unsigned OAM_LEN = OAM_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        reg_we,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  output logic [15:0] rd_addr,
  output logic        rd_en,
  input  logic [7:0]  rd_data,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_dout,
  output logic        oam_we,
  output logic        busy
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 32'd1);

  dma_state_t state_r;
  logic [7:0] src_r;
  logic [7:0] idx_r;
  logic [7:0] src_eff_s;
  logic       issue_s;

  assign src_eff_s = src_effective(src_r);
  // A CPU write on the same clk as ce wins, so that ce never issues a read.
  assign issue_s   = ce && !reg_we && (state_r == ST_XFER);

  // Control FSM, read issue and OAM write-back pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      src_r    <= 8'h00;
      idx_r    <= 8'h00;
      reg_dout <= 8'h00;
      rd_addr  <= 16'h0000;
      rd_en    <= 1'b0;
      oam_addr <= 8'h00;
      oam_dout <= 8'h00;
      oam_we   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rd_en  <= issue_s;
      // The write-back of a read in flight always completes, even across a restart.
      oam_we <= rd_en;
      if (rd_en) begin
        oam_addr <= rd_addr[7:0];
        oam_dout <= rd_data;
      end
      if (issue_s) begin
        rd_addr <= {src_eff_s, idx_r};
      end

      if (reg_we) begin
        reg_dout <= reg_din;
        src_r    <= reg_din;
        idx_r    <= 8'h00;
        state_r  <= ST_DELAY;
        busy     <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            // Reached one clk after the final read, i.e. with its oam_we.
            busy <= 1'b0;
          end
          ST_DELAY: begin
            busy <= 1'b1;
            if (ce) begin
              state_r <= ST_XFER;
            end
          end
          ST_XFER: begin
            busy <= 1'b1;
            if (ce) begin
              if (idx_r == LAST_IDX) begin
                state_r <= ST_IDLE;
                idx_r   <= 8'h00;
              end else begin
                idx_r <= idx_r + 8'd1;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
            idx_r   <= 8'h00;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: table of transfers plus hand-written
// restart, reset-abort and ce-stall sequences, checked through a scoreboard.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        reg_we;
  logic [7:0]  reg_din;
  logic [7:0]  reg_dout;
  logic [15:0] rd_addr;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_dout;
  logic        oam_we;
  logic        busy;

  always #5 clk = ~clk;

  oam_dma #(.OAM_LEN(160)) dut (
    .clk(clk), .rst(rst), .ce(ce), .reg_we(reg_we), .reg_din(reg_din),
    .reg_dout(reg_dout), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .oam_addr(oam_addr), .oam_dout(oam_dout), .oam_we(oam_we), .busy(busy)
  );

  // Source memory: page C0 holds i at offset i, other pages are distinct.
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ (a[15:8] - 8'hC0);
  endfunction

  assign rd_data = rd_en ? mem_val(rd_addr) : 8'h00;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       busy;
  } wr_t;

  typedef struct {
    logic [7:0] din;
    logic       same_ce;
    logic [7:0] exp_hi;
  } vec_t;

  logic [15:0] rdq[$];
  wr_t         wrq[$];
  logic [7:0]  oam_m [0:255];

  int checks = 0;
  int errors = 0;
  int rd_cnt, wr_cnt, ce_cnt, first_rd_ce, last_rd_ce;
  logic [15:0] first_rd, last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every read and OAM write is popped and compared.
  always @(negedge clk) begin
    if (rd_en === 1'b1) begin
      rd_cnt++;
      if (rd_cnt == 1) begin
        first_rd    = rd_addr;
        first_rd_ce = ce_cnt;
      end
      last_rd    = rd_addr;
      last_rd_ce = ce_cnt;
      if (rdq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got read at %h expected none", rd_addr);
      end else begin
        check("rd_addr", 32'(rd_addr), 32'(rdq.pop_front()));
      end
    end
    if (oam_we === 1'b1) begin
      wr_t e;
      wr_cnt++;
      oam_m[oam_addr] = oam_dout;
      if (wrq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got oam write %h=%h expected none", oam_addr, oam_dout);
      end else begin
        e = wrq.pop_front();
        check("oam_addr", 32'(oam_addr), 32'(e.addr));
        check("oam_dout", 32'(oam_dout), 32'(e.data));
        check("busy_at_write", 32'(busy), 32'(e.busy));
      end
    end
  end

  task automatic step(input logic c, input logic w, input logic [7:0] d);
    @(posedge clk);
    #1;
    ce = c;
    reg_we = w;
    reg_din = d;
    if (c && !w) ce_cnt++;
  endtask

  task automatic ce_pulse();
    step(1'b1, 1'b0, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_counts();
    rd_cnt = 0; wr_cnt = 0; ce_cnt = 0;
    first_rd_ce = 0; last_rd_ce = 0;
    first_rd = 16'h0000; last_rd = 16'h0000;
    for (int i = 0; i < 256; i++) oam_m[i] = 8'h5A;
  endtask

  task automatic push_reads(input logic [7:0] hi, input int n);
    for (int i = 0; i < n; i++) rdq.push_back({hi, 8'(i)});
  endtask

  task automatic push_writes(input logic [7:0] hi, input int n, input logic final_idle);
    for (int i = 0; i < n; i++)
      wrq.push_back('{addr: 8'(i), data: mem_val({hi, 8'(i)}),
                      busy: !(final_idle && (i == n - 1))});
  endtask

  task automatic start(input logic [7:0] din, input logic with_ce);
    step(with_ce, 1'b1, din);
    step(1'b0, 1'b0, 8'h00);
    check("busy_after_we", 32'(busy), 32'd1);
  endtask

  task automatic run_to_idle();
    for (int k = 0; k < 200; k++) begin
      if (!busy) break;
      ce_pulse();
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  function automatic int oam_bad(input logic [7:0] hi);
    int bad = 0;
    for (int i = 0; i < 160; i++)
      if (oam_m[i] !== mem_val({hi, 8'(i)})) bad++;
    return bad;
  endfunction

  vec_t vecs[6];

  initial begin
    int found;
    int quiet;
    logic [15:0] held;

    vecs[0] = '{din: 8'hC0, same_ce: 1'b0, exp_hi: 8'hC0};
    vecs[1] = '{din: 8'hE1, same_ce: 1'b0, exp_hi: 8'hC1};
    vecs[2] = '{din: 8'hE0, same_ce: 1'b1, exp_hi: 8'hC0};
    vecs[3] = '{din: 8'hDF, same_ce: 1'b0, exp_hi: 8'hDF};
    vecs[4] = '{din: 8'hFF, same_ce: 1'b1, exp_hi: 8'hDF};
    vecs[5] = '{din: 8'h00, same_ce: 1'b0, exp_hi: 8'h00};

    clear_counts();
    // Reset with reg_we and ce also asserted: reset must win.
    rst = 1'b1; ce = 1'b1; reg_we = 1'b1; reg_din = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_oam_we", 32'(oam_we), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_oam_addr", 32'(oam_addr), 32'd0);
    check("rst_oam_dout", 32'(oam_dout), 32'd0);
    check("rst_reg_dout", 32'(reg_dout), 32'd0);
    rst = 1'b0; ce = 1'b0; reg_we = 1'b0; reg_din = 8'h00;
    step(1'b0, 1'b0, 8'h00);
    check("post_rst_idle", 32'(busy), 32'd0);

    // Table of full transfers.
    for (int v = 0; v < 6; v++) begin
      clear_counts();
      push_reads(vecs[v].exp_hi, 160);
      push_writes(vecs[v].exp_hi, 160, 1'b1);
      start(vecs[v].din, vecs[v].same_ce);
      run_to_idle();
      check("wr_count", 32'(wr_cnt), 32'd160);
      check("rd_count", 32'(rd_cnt), 32'd160);
      check("first_rd", 32'(first_rd), 32'({vecs[v].exp_hi, 8'h00}));
      check("last_rd", 32'(last_rd), 32'({vecs[v].exp_hi, 8'h9F}));
      check("first_rd_ce", 32'(first_rd_ce), 32'd2);
      check("last_rd_ce", 32'(last_rd_ce), 32'd161);
      check("reg_dout", 32'(reg_dout), 32'(vecs[v].din));
      check("queues_empty", 32'(rdq.size() + wrq.size()), 32'd0);
      check("oam_contents_bad", 32'(oam_bad(vecs[v].exp_hi)), 32'd0);
    end

    // Restart at idx 50: source 80, then C0 while read 49 is in flight.
    clear_counts();
    push_reads(8'h80, 50);
    push_writes(8'h80, 50, 1'b0);
    start(8'h80, 1'b0);
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      if (rd_en && rd_addr == 16'h8031) found = 1;
      else repeat (2) step(1'b0, 1'b0, 8'h00);
    end
    check("restart_point_reached", 32'(found), 32'd1);
    push_reads(8'hC0, 160);
    push_writes(8'hC0, 160, 1'b1);
    reg_we = 1'b1; reg_din = 8'hC0;
    step(1'b0, 1'b0, 8'h00);
    rd_cnt = 0; ce_cnt = 0;
    check("restart_busy", 32'(busy), 32'd1);
    run_to_idle();
    check("restart_wr_total", 32'(wr_cnt), 32'd210);
    check("restart_first_rd", 32'(first_rd), 32'hC000);
    check("restart_first_rd_ce", 32'(first_rd_ce), 32'd2);
    check("restart_last_rd", 32'(last_rd), 32'hC09F);
    check("restart_queues_empty", 32'(rdq.size() + wrq.size()), 32'd0);
    check("restart_oam_bad", 32'(oam_bad(8'hC0)), 32'd0);

    // Reset abort while the read of idx 10 is outstanding.
    clear_counts();
    push_reads(8'hC0, 11);
    push_writes(8'hC0, 10, 1'b0);
    start(8'hC0, 1'b0);
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      if (rd_en && rd_addr == 16'hC00A) found = 1;
      else repeat (2) step(1'b0, 1'b0, 8'h00);
    end
    check("abort_point_reached", 32'(found), 32'd1);
    rst = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    check("abort_oam_we", 32'(oam_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_reg_dout", 32'(reg_dout), 32'd0);
    rst = 1'b0;
    repeat (5) ce_pulse();
    check("abort_wr_count", 32'(wr_cnt), 32'd10);
    check("abort_busy_later", 32'(busy), 32'd0);
    check("abort_queues_empty", 32'(rdq.size() + wrq.size()), 32'd0);

    // ce held low for 20 clk mid-transfer.
    clear_counts();
    push_reads(8'hC0, 160);
    push_writes(8'hC0, 160, 1'b1);
    start(8'hC0, 1'b0);
    for (int k = 0; k < 100 && rd_cnt < 30; k++) ce_pulse();
    held = rd_addr;
    quiet = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, 8'h00);
      if (rd_en || oam_we || rd_addr != held) quiet++;
    end
    check("stall_held_addr", 32'(held), 32'hC01D);
    check("stall_activity", 32'(quiet), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    run_to_idle();
    check("stall_wr_count", 32'(wr_cnt), 32'd160);
    check("stall_last_rd", 32'(last_rd), 32'hC09F);
    check("stall_oam_bad", 32'(oam_bad(8'hC0)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have param OAM_LEN, default 160, meaning bytes per transfer.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ce  input  1  machine-cycle strobe, one clk wide.
REQ-005 SHALL have port reg_we  input  1  CPU write strobe to DMA register (FF46).
REQ-006 SHALL have port reg_din  input  8  source high byte written by CPU.
REQ-007 SHALL have port reg_dout  output  8  readback of last written source byte.
REQ-008 SHALL have port rd_addr  output  16  source read address to memory.
REQ-009 SHALL have port rd_en  output  1  source read request; one clk wide.
REQ-010 SHALL have port rd_data  input  8  source data, valid one clk after rd_en.
REQ-011 SHALL have port oam_addr  output  8  OAM byte index 0..OAM_LEN-1.
REQ-012 SHALL have port oam_dout  output  8  byte to write into OAM.
REQ-013 SHALL have port oam_we  output  1  OAM write strobe; one clk wide.
REQ-014 SHALL have port busy  output  1  high while a transfer is pending or active; CPU bus arbitration uses it.

Function
REQ-015 SHALL implement FSM states IDLE, DELAY, XFER.
REQ-016 IDLE: on reg_we, SHALL latch reg_din into src, clear idx to 0, enter DELAY, assert busy next clk.
REQ-017 DELAY: SHALL wait for exactly one ce, then enter XFER; no read issued on that ce.
REQ-018 XFER: on each ce SHALL pulse rd_en for one clk with rd_addr = {src_eff, idx}.
REQ-019 src_eff SHALL equal src - 8'h20 when src >= 8'hE0 (echo-RAM mirror), else src.
REQ-020 One clk after each rd_en, SHALL pulse oam_we with oam_addr = idx of that read and oam_dout = rd_data.
REQ-021 After the read with idx = OAM_LEN-1, SHALL enter IDLE; busy SHALL drop in the same clk as the final oam_we.
REQ-022 idx SHALL increment by 1 per issued read and never exceed OAM_LEN-1; no wrap into 8'hA0..8'hFF.
REQ-023 reg_dout SHALL always equal the last value written via reg_we, independent of state.
REQ-024 Restart: reg_we in DELAY or XFER SHALL relatch src, clear idx, enter DELAY, keep busy high.
REQ-025 A read already issued before the restart SHALL still complete its oam_we on the following clk.
REQ-026 reg_we and ce in the same clk: reg_we SHALL take priority; that ce SHALL issue no read and SHALL NOT count toward DELAY.
REQ-027 Without ce, the FSM SHALL hold state and idx; rd_en and oam_we SHALL stay low.
REQ-028 Transfer SHALL take 1 + OAM_LEN ce pulses from reg_we to the final read.

Reset
REQ-029 rst SHALL force IDLE, idx = 0, src = 8'h00, reg_dout = 8'h00, and busy, rd_en, oam_we = 0.
REQ-030 rst SHALL force rd_addr = 16'h0000, oam_addr = 8'h00, oam_dout = 8'h00.
REQ-031 rst mid-transfer SHALL abort it; no oam_we SHALL occur after rst is asserted, including a pending write.
REQ-032 rst SHALL take priority over reg_we and ce.

Structure
REQ-033 State enum, OAM_LEN default, ECHO_BASE = 8'hE0 and ECHO_OFFSET = 8'h20 SHALL live in shared package gb_dma_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the memory model is external on the bench.

Verification
REQ-035 Write 8'hC0, ce every 4 clk, RAM C000+i = i -> 160 oam_we, OAM[i] = i, busy low after write 159.
REQ-036 Write 8'hE1 -> first rd_addr = 16'hC100, last rd_addr = 16'hC19F.
REQ-037 Write 8'h80, then at idx = 50 write 8'hC0 -> write 49 completes, then DELAY, then idx restarts at 0 from C000; 210 oam_we in total.
REQ-038 Assert rst at idx = 10 with a read outstanding -> no further oam_we, busy = 0, reg_dout = 8'h00.
REQ-039 reg_we in the same clk as ce -> the first rd_en appears on the 2nd subsequent ce, not the 1st.
REQ-040 Hold ce low for 20 clk mid-XFER -> no rd_en or oam_we, idx unchanged, and the transfer resumes correctly.
